// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
//   Shared definitions for the I2S transmitter:
//     - default geometry (sample width, slot width, MCLK divider)
//     - word-select encoding (LR_LEFT / LR_RIGHT)
//     - CNT_W(): width of the free-running frame counter, which holds
//       MCLK_DIV * 2 * SLOT_W states (one full stereo frame)
// -----------------------------------------------------------------------------
package i2s_pkg;

  localparam int SAMPLE_W_DEF = 16;  // bits per channel sample
  localparam int SLOT_W_DEF   = 32;  // BCLK periods per channel slot
  localparam int MCLK_DIV_DEF = 4;   // MCLK cycles per BCLK (power of 2, >= 2)

  // Word-select level on i2s_lrclk.
  typedef enum logic {
    LR_LEFT  = 1'b0,
    LR_RIGHT = 1'b1
  } lr_e;

  // Counter width for one stereo frame of MCLK cycles.
  // With the defaults: 4 * 2 * 32 = 256 states -> 8 bits.
  function automatic int CNT_W(input int slot_w, input int mclk_div);
    return $clog2(mclk_div * 2 * slot_w);
  endfunction

endpackage : i2s_pkg

// File: rtl/i2s_tx_if.sv
// -----------------------------------------------------------------------------
// i2s_tx_if
//   Sample-pair stream from the upstream source (WAV reader / CDC FIFO) into
//   the I2S transmitter. A pair transfers on a clock where in_valid and
//   in_ready are both high. The source keeps in_left/in_right stable while
//   in_valid is high.
//
//   Signals
//     in_valid   source -> tx   sample pair valid
//     in_left    source -> tx   left sample, two's complement, SAMPLE_W bits
//     in_right   source -> tx   right sample, two's complement, SAMPLE_W bits
//     in_ready   tx -> source   transmitter holding register is empty
//
//   Modports
//     master : the sample source
//     slave  : the transmitter (i2s_tx)
// -----------------------------------------------------------------------------
interface i2s_tx_if
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) ();

  logic                in_valid;
  logic [SAMPLE_W-1:0] in_left;
  logic [SAMPLE_W-1:0] in_right;
  logic                in_ready;

  modport master (
    output in_valid,
    output in_left,
    output in_right,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_left,
    input  in_right,
    output in_ready
  );

endinterface : i2s_tx_if

// File: rtl/i2s_tx_clkgen.sv
// -----------------------------------------------------------------------------
// i2s_tx_clkgen
//   Frame timing for the I2S transmitter. A single free-running counter spans
//   one stereo frame of MCLK cycles; its upper bits are the bit index k
//   (0 .. 2*SLOT_W-1) and its lower bits are the phase inside one BCLK period.
//
//   bclk and lrclk are registered, so they trail the counter by one clk.
//   shift_en and frame_load are combinational strobes decoded from the
//   current counter value and are used by the datapath in the same cycle.
//
//   Ports
//     clk         in   audio master clock (MCLK)
//     rst_n       in   asynchronous reset, active low
//     en          in   run enable; when low the counter is held at 0 and
//                      bclk/lrclk are driven low
//     bclk        out  registered bit clock, clk / MCLK_DIV
//     lrclk       out  registered word select (0 = left, 1 = right)
//     shift_en    out  last MCLK of the current BCLK period
//     frame_load  out  last MCLK of the frame (counter at its maximum)
// -----------------------------------------------------------------------------
module i2s_tx_clkgen
  import i2s_pkg::*;
#(
  parameter int SLOT_W   = SLOT_W_DEF,
  parameter int MCLK_DIV = MCLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bclk,
  output logic lrclk,
  output logic shift_en,
  output logic frame_load
);

  localparam int CW = CNT_W(SLOT_W, MCLK_DIV);  // frame counter width
  localparam int PW = $clog2(MCLK_DIV);         // BCLK phase width
  localparam int KW = CW - PW;                  // bit index width

  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] phase;
  logic [KW-1:0] bit_idx;
  logic [KW-1:0] bit_idx_next;
  logic          bclk_q, bclk_d;
  lr_e           lrclk_q, lrclk_d;

  assign phase   = cnt_q[PW-1:0];
  assign bit_idx = cnt_q[CW-1:PW];

  // NOTE: every signal written here gets a default before any condition, so
  // no path through the block leaves a value unassigned and no latch is built.
  always_comb begin
    cnt_d        = '0;
    bit_idx_next = bit_idx + KW'(1);
    bclk_d       = 1'b0;
    lrclk_d      = LR_LEFT;

    if (en) begin
      // Wraps naturally from all-ones to zero at the end of the frame.
      cnt_d  = cnt_q + CW'(1);
      // Low in the first half of the BCLK period, high in the second.
      bclk_d = phase[PW-1];
      // Word select switches one BCLK ahead of the slot it announces:
      // lrclk is high for k = SLOT_W-1 .. 2*SLOT_W-2. Testing k+1 (modulo
      // the frame) against SLOT_W gives exactly that window, including the
      // low level at k = 2*SLOT_W-1 where k+1 wraps to 0.
      if (bit_idx_next >= KW'(SLOT_W)) begin
        lrclk_d = LR_RIGHT;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= LR_LEFT;
    end else begin
      cnt_q   <= cnt_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
    end
  end

  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign shift_en   = en && (phase == {PW{1'b1}});
  assign frame_load = en && (cnt_q == {CW{1'b1}});

endmodule : i2s_tx_clkgen

// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx
//   Serialises stereo PCM sample pairs onto an I2S bus for the audio DAC.
//   Runs entirely in the MCLK domain (MCLK = 256 * Fs with the defaults);
//   BCLK and LRCLK are derived internally by i2s_tx_clkgen.
//
//   Data path
//     - One holding register accepts a sample pair from the source whenever
//       it is empty (in_ready = !hold_full).
//     - On the last clk of each frame the holding register moves into a
//       2*SLOT_W-bit shift register laid out as
//         { left, zero pad, right, zero pad }
//       MSB first. If the holding register is empty at that moment the shift
//       register loads silence and underrun pulses for that one clk.
//     - A pair accepted in the load cycle is not bypassed into the shift
//       register; it stays in the holding register for the following frame.
//     - The shift register advances one bit at the end of each BCLK period,
//       so i2s_sdata changes together with the falling edge of i2s_bclk.
//
//   Enable
//     en low holds the frame counter at 0, clears the shift register and
//     drives bclk/lrclk/sdata low. The handshake keeps working, so one pair
//     may wait in the holding register; it plays in the second frame after en
//     rises, because the first frame always starts from a cleared shift
//     register. That first frame never reports an underrun.
//
//   Ports
//     clk           in   audio master clock (MCLK)
//     rst_n         in   asynchronous reset, active low
//     en            in   serializer run enable
//     in_if         -    sample-pair stream (i2s_tx_if.slave)
//     i2s_bclk      out  bit clock = clk / MCLK_DIV (registered)
//     i2s_lrclk     out  word select, 0 = left, 1 = right (registered)
//     i2s_sdata     out  serial data, MSB first (registered)
//     underrun      out  one-clk pulse: frame started with no pair available
//     underrun_cnt  out  saturating underrun count (only with
//                        I2S_TX_UNDERRUN_CNT_EN defined)
//
//   Configuration
//     I2S_TX_UNDERRUN_CNT_EN : adds underrun_cnt[15:0], a 16-bit saturating
//                              count of underrun pulses cleared only by rst_n.
// -----------------------------------------------------------------------------
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int SLOT_W   = SLOT_W_DEF,
  parameter int MCLK_DIV = MCLK_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  i2s_tx_if.slave     in_if,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);

  localparam int FRAME_W = 2 * SLOT_W;

  // ---------------------------------------------------------------------------
  // Frame timing
  // ---------------------------------------------------------------------------
  logic shift_en;
  logic frame_load;

  i2s_tx_clkgen #(
    .SLOT_W   (SLOT_W),
    .MCLK_DIV (MCLK_DIV)
  ) u_clkgen (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .bclk       (i2s_bclk),
    .lrclk      (i2s_lrclk),
    .shift_en   (shift_en),
    .frame_load (frame_load)
  );

  // ---------------------------------------------------------------------------
  // Holding register and handshake
  // ---------------------------------------------------------------------------
  logic                hold_full_q, hold_full_d;
  logic [SAMPLE_W-1:0] hold_left_q, hold_left_d;
  logic [SAMPLE_W-1:0] hold_right_q, hold_right_d;
  logic                accept;

  assign in_if.in_ready = !hold_full_q;
  assign accept         = in_if.in_valid && !hold_full_q;

  always_comb begin
    hold_full_d  = hold_full_q;
    hold_left_d  = hold_left_q;
    hold_right_d = hold_right_q;

    if (accept) begin
      hold_left_d  = in_if.in_left;
      hold_right_d = in_if.in_right;
    end

    // The load empties the holding register; an accept in the same cycle
    // refills it, so the result is simply "was there an accept".
    if (frame_load) begin
      hold_full_d = accept;
    end else if (accept) begin
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full_q <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
    end
  end

  // NOTE: the sample data flops carry no reset; their contents are only
  // consumed while hold_full_q is set, and that flag is reset.
  always_ff @(posedge clk) begin
    hold_left_q  <= hold_left_d;
    hold_right_q <= hold_right_d;
  end

  // ---------------------------------------------------------------------------
  // Shift register and serial data
  // ---------------------------------------------------------------------------
  // Left-justify a sample in its slot: MSB at the slot MSB, zeros after LSB.
  function automatic logic [SLOT_W-1:0] to_slot(input logic [SAMPLE_W-1:0] s);
    return SLOT_W'(s) << (SLOT_W - SAMPLE_W);
  endfunction

  logic [FRAME_W-1:0] hold_frame;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               sdata_q, sdata_d;

  assign hold_frame = {to_slot(hold_left_q), to_slot(hold_right_q)};

  always_comb begin
    shift_d = shift_q;
    sdata_d = 1'b0;

    if (!en) begin
      shift_d = '0;
    end else if (frame_load) begin
      // The load takes priority over the regular end-of-BCLK shift that
      // falls on the same clk.
      shift_d = hold_full_q ? hold_frame : '0;
    end else if (shift_en) begin
      shift_d = shift_q << 1;
    end

    if (en) begin
      sdata_d = shift_q[FRAME_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      sdata_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      sdata_q <= sdata_d;
    end
  end

  assign i2s_sdata = sdata_q;

  // A frame boundary with nothing waiting is an underrun. frame_load is never
  // asserted while en is low, so the silent first frame after enabling does
  // not raise it.
  assign underrun = frame_load && !hold_full_q;

  // ---------------------------------------------------------------------------
  // Optional underrun statistics
  // ---------------------------------------------------------------------------
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ur_cnt_q, ur_cnt_d;

  always_comb begin
    ur_cnt_d = ur_cnt_q;
    if (underrun && (ur_cnt_q != 16'hFFFF)) begin
      ur_cnt_d = ur_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ur_cnt_q <= '0;
    end else begin
      ur_cnt_q <= ur_cnt_d;
    end
  end

  assign underrun_cnt = ur_cnt_q;
`endif

endmodule : i2s_tx

// File: tb/tb_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx
//   Directed self-checking bench for i2s_tx at the default geometry
//   (SAMPLE_W=16, SLOT_W=32, MCLK_DIV=4 -> 256 clk per frame).
//
//   Timeline reference: t counts rising clk edges since en was last raised.
//   At the falling edge after edge t the frame counter holds t mod 256 and
//   the registered i2s_* outputs reflect counter value c = (t-1) mod 256 of
//   frame (t-1)/256. Expected frame contents are written as hand-built
//   64-bit words {left, 16'h0, right, 16'h0}.
// -----------------------------------------------------------------------------
module tb_i2s_tx;

  logic clk;
  logic rst_n;
  logic en;
  logic i2s_bclk;
  logic i2s_lrclk;
  logic i2s_sdata;
  logic underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  i2s_tx_if #(.SAMPLE_W(16)) in_if ();

  i2s_tx #(
    .SAMPLE_W (16),
    .SLOT_W   (32),
    .MCLK_DIV (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_if     (in_if),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_sdata (i2s_sdata),
    .underrun  (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          t     = 0;
  logic [63:0] frames [0:15];   // expected serial content of each frame
  bit          ur_exp [0:15];   // expected underrun at the load starting frame f
  logic [15:0] sl [0:2];
  logic [15:0] sr [0:2];
  int          idx;
  bit          exp_rdy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h at t=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic init_model();
    for (int i = 0; i < 16; i++) begin
      frames[i] = '0;
      ur_exp[i] = 1'b1;
    end
    ur_exp[0] = 1'b0;
  endtask

  // Running: advance n clks, checking every output against the frame model.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      int          c;
      int          k;
      int          f;
      logic [63:0] fr;
      @(posedge clk);
      t++;
      @(negedge clk);
      c  = (t - 1) % 256;
      f  = (t - 1) / 256;
      k  = c / 4;
      fr = frames[f];
      check("bclk", i2s_bclk, (c % 4) >= 2);
      check("lrclk", i2s_lrclk, ((k + 1) % 64) >= 32);
      check("sdata", i2s_sdata, fr[63-k]);
      check("underrun", underrun, (t % 256 == 255) ? ur_exp[(t+1)/256] : 1'b0);
    end
  endtask

  task automatic run_to(input int target);
    run(target - t);
  endtask

  // Disabled: outputs must stay quiet.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check("bclk_off", i2s_bclk, 0);
      check("lrclk_off", i2s_lrclk, 0);
      check("sdata_off", i2s_sdata, 0);
      check("underrun_off", underrun, 0);
    end
  endtask

  // One-pair transfer into an empty holding register.
  task automatic push(input logic [15:0] l, input logic [15:0] r);
    in_if.in_left  = l;
    in_if.in_right = r;
    in_if.in_valid = 1'b1;
    check("ready_pre", in_if.in_ready, 1);
    if (en) run(1);
    else    idle(1);
    in_if.in_valid = 1'b0;
    check("ready_post", in_if.in_ready, 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    en             = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_left  = '0;
    in_if.in_right = '0;
    sl[0] = 16'h1234; sr[0] = 16'hFEDC;
    sl[1] = 16'h7FFF; sr[1] = 16'h8000;
    sl[2] = 16'h0001; sr[2] = 16'hFFFF;
    init_model();

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_bclk", i2s_bclk, 0);
    check("rst_lrclk", i2s_lrclk, 0);
    check("rst_sdata", i2s_sdata, 0);
    check("rst_ready", in_if.in_ready, 1);
    check("rst_underrun", underrun, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("rst_ur_cnt", underrun_cnt, 0);
`endif
    rst_n = 1'b1;
    idle(8);
    check("idle_ready", in_if.in_ready, 1);

    // ---- main run: expected frame plan ----
    frames[2] = 64'hA5C3_0000_8001_0000; ur_exp[2] = 1'b0;
    frames[3] = 64'h1234_0000_FEDC_0000; ur_exp[3] = 1'b0;
    frames[4] = 64'h7FFF_0000_8000_0000; ur_exp[4] = 1'b0;
    frames[5] = 64'h0001_0000_FFFF_0000; ur_exp[5] = 1'b0;
    ur_exp[6] = 1'b1;
    frames[7] = 64'hC0DE_0000_0FF0_0000; ur_exp[7] = 1'b0;

    en = 1'b1;
    t  = 0;
    // Frames 0/1 silent, underrun at t=255 only.
    run_to(300);
    push(16'hA5C3, 16'h8001);
    run_to(600);

    // Continuous in_valid: ready only right after each frame load.
    idx            = 0;
    in_if.in_left  = sl[0];
    in_if.in_right = sr[0];
    in_if.in_valid = 1'b1;
    while (idx < 3) begin
      exp_rdy = (t == 600) || (t % 256 == 0);
      check("stream_ready", in_if.in_ready, exp_rdy);
      run(1);
      if (exp_rdy) begin
        idx++;
        if (idx < 3) begin
          in_if.in_left  = sl[idx];
          in_if.in_right = sr[idx];
        end else begin
          in_if.in_valid = 1'b0;
        end
      end
    end

    // Accept in the cnt=255 cycle with the holding register empty.
    run_to(1535);
    check("ur_at_load", underrun, 1);
    push(16'hC0DE, 16'h0FF0);

    // Leave a pair waiting, then reset at k=40 of frame 7.
    run_to(1800);
    push(16'h5555, 16'hAAAA);
    run_to(1955);
    check("pre_rst_bclk", i2s_bclk, 1);
    check("pre_rst_lrclk", i2s_lrclk, 1);
    check("pre_rst_sdata", i2s_sdata, 1);
    check("pre_rst_ready", in_if.in_ready, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("ur_cnt", underrun_cnt, 2);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("arst_bclk", i2s_bclk, 0);
    check("arst_lrclk", i2s_lrclk, 0);
    check("arst_sdata", i2s_sdata, 0);
    check("arst_ready", in_if.in_ready, 1);
    check("arst_underrun", underrun, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("arst_ur_cnt", underrun_cnt, 0);
`endif
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    check("post_rst_ready", in_if.in_ready, 1);

    // ---- restart: discarded hold, then en dropped mid-frame ----
    init_model();
    frames[1] = 64'hF00F_0000_3333_0000; ur_exp[1] = 1'b0;
    en = 1'b1;
    t  = 0;
    run_to(10);
    push(16'hF00F, 16'h3333);
    run_to(300);
    en = 1'b0;
    idle(20);
    check("en0_ready", in_if.in_ready, 1);
    push(16'h8421, 16'h1248);
    idle(10);

    // ---- re-enable: silent first frame, buffered pair in the second ----
    init_model();
    frames[1] = 64'h8421_0000_1248_0000; ur_exp[1] = 1'b0;
    en = 1'b1;
    t  = 0;
    run_to(520);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_i2s_tx
